// File: rtl/uart_byte_rx_pkg.sv
// +----------------------------------------------------------------------+
// | uart_byte_rx_pkg : shared receiver states, vote points and helpers   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package uart_byte_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

  // Three votes straddle the middle of each 16-sample bit; the last one decides.
  localparam logic [3:0] c_vote_first = 4'd7;
  localparam logic [3:0] c_vote_mid   = 4'd8;
  localparam logic [3:0] c_vote_last  = 4'd9;
  localparam logic [3:0] c_bit_last   = 4'd15;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// +----------------------------------------------------------------------+
// | uart_baud_tick : oversample tick generator, realignable via clr      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module uart_baud_tick
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic s_tick
);

  localparam int c_div   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_div - 1);

  generate
    if (c_div < 1) begin : g_div_check
      $error("uart_baud_tick: divider below 1 for CLK_FREQ/BAUD combination");
    end
    if (OVERSAMPLE != 16) begin : g_os_check
      $error("uart_baud_tick: only 16x oversampling is supported");
    end
  endgenerate

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_max) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign s_tick = (r_cnt == c_cnt_max);

endmodule

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// +----------------------------------------------------------------------+
// | uart_byte_rx : 8N1 receiver, 16x oversampled, 3-sample majority vote |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync3;
  logic [1:0] r_warm;
  logic       r_armed;

  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  logic       w_valid_nxt;
  logic       w_ferr_nxt;

  logic       w_tick;
  logic       r_tick_d;
  logic [3:0] r_scnt;
  logic [3:0] r_hcnt;
  logic [2:0] r_idx;
  logic       r_taken;
  logic [7:0] r_shreg;
  logic       r_v0;
  logic       r_v1;

  logic       w_rxd;
  logic       w_fall;
  logic       w_start;
  logic       w_decide;
  logic       w_vote;
  logic       w_bit_end;

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_start),
    .s_tick (w_tick)
  );

  // Arming waits for the preset synchroniser contents to flush, so a line
  // that is already low at reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
      r_warm  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (r_warm != 2'd3) begin
        r_warm <= r_warm + 2'd1;
      end else if (r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_rxd     = r_sync2;
  assign w_fall    = r_sync3 & ~r_sync2 & r_armed;
  assign w_start   = (r_state == S_IDLE) && w_fall;
  assign w_decide  = r_tick_d && (r_scnt == c_vote_last);
  assign w_vote    = majority3(r_v0, r_v1, w_rxd);
  assign w_bit_end = w_tick && (r_scnt == c_bit_last);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_decide) begin
          w_state_nxt = w_vote ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end && r_taken && (r_idx == 3'd7)) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at the decision point rather than the bit end leaves room
        // to catch a back-to-back start from a slightly fast transmitter.
        if (w_decide) begin
          if (w_vote) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = S_BREAK;
            w_ferr_nxt  = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (w_tick && w_rxd && (r_hcnt == 4'd15)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_d  <= 1'b0;
      r_scnt    <= 4'd0;
      r_hcnt    <= 4'd0;
      r_idx     <= 3'd0;
      r_taken   <= 1'b0;
      r_shreg   <= 8'd0;
      r_v0      <= 1'b1;
      r_v1      <= 1'b1;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= w_valid_nxt;
      frame_err <= w_ferr_nxt;
      r_tick_d  <= w_tick & ~w_start;

      if (w_start) begin
        r_scnt <= 4'd0;
      end else if (w_tick) begin
        r_scnt <= r_scnt + 4'd1;
      end

      if (r_tick_d && (r_scnt == c_vote_first)) begin
        r_v0 <= w_rxd;
      end
      if (r_tick_d && (r_scnt == c_vote_mid)) begin
        r_v1 <= w_rxd;
      end

      // r_taken keeps the tail of the start bit from advancing the index.
      if (w_start) begin
        r_idx   <= 3'd0;
        r_taken <= 1'b0;
      end else if (r_state == S_DATA) begin
        if (w_decide) begin
          r_shreg[r_idx] <= w_vote;
          r_taken        <= 1'b1;
        end else if (w_bit_end && r_taken) begin
          r_taken <= 1'b0;
          r_idx   <= r_idx + 3'd1;
        end
      end

      if (w_valid_nxt) begin
        rx_data <= r_shreg;
      end

      if (r_state != S_BREAK) begin
        r_hcnt <= 4'd0;
      end else if (w_tick) begin
        r_hcnt <= w_rxd ? (r_hcnt + 4'd1) : 4'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
// +----------------------------------------------------------------------+
// | tb_uart_byte_rx : directed + randomised bench for uart_byte_rx       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ps/1ps

module tb_uart_byte_rx;

  localparam int CLK_PS  = 10000;
  localparam int BIT_PS  = 32 * CLK_PS;
  localparam int FAST_PS = 310680;   // BAUD + 3%
  localparam int SLOW_PS = 329897;   // BAUD - 3%

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  always #(CLK_PS / 2) clk = ~clk;

  uart_byte_rx #(
    .CLK_FREQ   (3_686_400),
    .BAUD       (115200),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Strobe collector
  logic [7:0] got_q[$];
  int         ferr_cnt     = 0;
  int         width_viol   = 0;
  int         overlap_viol = 0;
  logic       prev_valid   = 1'b0;
  logic       prev_ferr    = 1'b0;
  longint     last_valid_t = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      got_q.push_back(rx_data);
      last_valid_t = $time;
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if ((rx_valid === 1'b1) && prev_valid) width_viol++;
    if ((frame_err === 1'b1) && prev_ferr) width_viol++;
    if ((rx_valid === 1'b1) && (frame_err === 1'b1)) overlap_viol++;
    prev_valid = (rx_valid === 1'b1);
    prev_ferr  = (frame_err === 1'b1);
  end

  // Reference model: a frame with a high stop bit delivers its byte,
  // a low stop bit yields one frame error and no byte.
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit_ps, input logic stop_bit);
    rxd = 1'b0;
    #(bit_ps);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ps);
    end
    rxd = stop_bit;
    #(bit_ps);
    if (stop_bit) exp_q.push_back(b);
  endtask

  task automatic check_rx(input string tag, input int base);
    check({tag, "_count"}, 128'(got_q.size() - base), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) begin
        check($sformatf("%s_byte%0d", tag, i), 128'(got_q[base + i]), 128'(exp_q[i]));
      end
    end
  endtask

  initial begin
    int           base;
    int           fbase;
    logic [127:0] batch;
    longint       t0;
    longint       lat;

    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({rx_data, rx_valid, frame_err, busy}), 128'd0);
    reset = 1'b0;
    #(2 * BIT_PS + 1000 + $urandom_range(0, 3000));

    // 1: two isolated bytes, latency window
    base = got_q.size(); fbase = ferr_cnt; exp_q.delete();
    t0 = $time;
    send_frame(8'hA5, BIT_PS, 1'b1);
    #(BIT_PS);
    lat = (last_valid_t - t0) / CLK_PS;
    check("t1_latency_300_316", 128'((lat >= 300) && (lat <= 316)), 128'd1);
    send_frame(8'h3C, BIT_PS, 1'b1);
    #(2 * BIT_PS);
    check_rx("t1", base);
    check("t1_frame_err", 128'(ferr_cnt - fbase), 128'd0);

    // 2: sixteen back-to-back frames packed into a 128-bit batch
    base = got_q.size(); fbase = ferr_cnt; exp_q.delete();
    for (int i = 0; i < 16; i++) send_frame(8'(i), BIT_PS, 1'b1);
    #(2 * BIT_PS);
    check_rx("t2", base);
    batch = '0;
    for (int i = 0; i < 16; i++) begin
      if (base + i < got_q.size()) batch = {batch[119:0], got_q[base + i]};
    end
    check("t2_batch", batch, 128'h000102030405060708090a0b0c0d0e0f);

    // 3: 10-clk glitch is a false start
    base = got_q.size(); fbase = ferr_cnt;
    rxd = 1'b0;
    #(10 * CLK_PS);
    rxd = 1'b1;
    @(negedge clk);
    check("t3_busy_during_glitch", 128'(busy), 128'd1);
    #(2 * BIT_PS);
    @(negedge clk);
    check("t3_busy_after_glitch", 128'(busy), 128'd0);
    check("t3_no_valid", 128'(got_q.size() - base), 128'd0);
    check("t3_no_frame_err", 128'(ferr_cnt - fbase), 128'd0);
    #(1000 + $urandom_range(0, 3000));

    // 4: low stop bit, held break, then a clean byte
    base = got_q.size(); fbase = ferr_cnt; exp_q.delete();
    send_frame(8'h55, BIT_PS, 1'b0);
    #(3 * BIT_PS);
    @(negedge clk);
    check("t4_busy_in_break", 128'(busy), 128'd1);
    check("t4_one_frame_err", 128'(ferr_cnt - fbase), 128'd1);
    check("t4_no_valid_in_break", 128'(got_q.size() - base), 128'd0);
    #(1000 + $urandom_range(0, 3000));
    rxd = 1'b1;
    #(2 * BIT_PS);
    @(negedge clk);
    check("t4_idle_after_break", 128'(busy), 128'd0);
    #(1000 + $urandom_range(0, 3000));
    send_frame(8'h81, BIT_PS, 1'b1);
    #(2 * BIT_PS);
    check_rx("t4", base);
    check("t4_frame_err_total", 128'(ferr_cnt - fbase), 128'd1);

    // 5: 2-clk low spike near the middle of data bit 3 of 0xFF
    base = got_q.size(); exp_q.delete();
    rxd = 1'b0;
    #(BIT_PS);
    rxd = 1'b1;
    #(3 * BIT_PS + 165000);
    rxd = 1'b0;
    #(2 * CLK_PS);
    rxd = 1'b1;
    #(BIT_PS - 185000 + 4 * BIT_PS);
    #(BIT_PS);
    exp_q.push_back(8'hFF);
    #(2 * BIT_PS);
    check_rx("t5", base);

    // 6: reset pulse in the middle of data bit 3 of 0x96
    base = got_q.size(); fbase = ferr_cnt; exp_q.delete();
    rxd = 1'b0;
    #(BIT_PS);
    rxd = 1'b0; #(BIT_PS);
    rxd = 1'b1; #(BIT_PS);
    rxd = 1'b1; #(BIT_PS);
    rxd = 1'b0; #(BIT_PS / 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_busy_after_reset", 128'(busy), 128'd0);
    rxd = 1'b1;
    #(3 * BIT_PS + 1000 + $urandom_range(0, 3000));
    check("t6_no_strobe", 128'(got_q.size() - base), 128'd0);
    send_frame(8'h42, BIT_PS, 1'b1);
    #(2 * BIT_PS);
    check_rx("t6", base);
    check("t6_no_frame_err", 128'(ferr_cnt - fbase), 128'd0);

    // 7: +/-3% baud skew, random back-to-back bytes
    base = got_q.size(); fbase = ferr_cnt; exp_q.delete();
    for (int i = 0; i < 32; i++) send_frame(8'($urandom), FAST_PS, 1'b1);
    #(2 * BIT_PS);
    check_rx("t7_fast", base);
    check("t7_fast_frame_err", 128'(ferr_cnt - fbase), 128'd0);

    base = got_q.size(); fbase = ferr_cnt; exp_q.delete();
    for (int i = 0; i < 32; i++) send_frame(8'($urandom), SLOW_PS, 1'b1);
    #(2 * BIT_PS);
    check_rx("t7_slow", base);
    check("t7_slow_frame_err", 128'(ferr_cnt - fbase), 128'd0);

    check("strobe_width_1cycle", 128'(width_viol), 128'd0);
    check("valid_ferr_exclusive", 128'(overlap_viol), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
